// File: rtl/ysyx_mem_arbiter_if.sv
// Memory-port channel: valid/ready request carrying addr/write fields and a
// valid/ready response carrying read data. Used for IFU, LSU and memory sides.
interface ysyx_mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [31:0]       wdata;
    logic [3:0]        wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rdata;

    modport master (
        output req_valid, addr, wen, wdata, wmask, rsp_ready,
        input  req_ready, rsp_valid, rdata
    );

    modport slave (
        input  req_valid, addr, wen, wdata, wmask, rsp_ready,
        output req_ready, rsp_valid, rdata
    );
endinterface

// File: rtl/ysyx_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one memory port arbiter.
// One transaction in flight; round-robin on simultaneous requests.
module ysyx_mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    ysyx_mem_arbiter_if.slave  ifu,
    ysyx_mem_arbiter_if.slave  lsu,
    ysyx_mem_arbiter_if.master mem,
    output logic               busy,
    output logic               grant_lsu
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_lsu_q, last_lsu_d;
    logic              grant_lsu_q, grant_lsu_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;

    logic pick_lsu;
    logic ifu_acc;
    logic lsu_acc;
    logic rsp_ready_sel;
    logic rsp_hs;
    logic in_resp;

    // IFU only presents reads, so its write-side channel fields are never used.
    logic ifu_unused;
    assign ifu_unused = ^{ifu.wen, ifu.wdata, ifu.wmask};

    // A lone requester always wins; on a tie the LSU wins only if the IFU
    // owned the last completed transaction.
    always_comb begin
        pick_lsu      = lsu.req_valid && (!ifu.req_valid || !last_lsu_q);
        ifu_acc       = (state_q == IDLE) && ifu.req_valid && !pick_lsu;
        lsu_acc       = (state_q == IDLE) && pick_lsu;
        in_resp       = (state_q == RESP);
        rsp_ready_sel = grant_lsu_q ? lsu.rsp_ready : ifu.rsp_ready;
        rsp_hs        = in_resp && mem.rsp_valid && rsp_ready_sel;
    end

    always_comb begin
        state_d     = state_q;
        last_lsu_d  = last_lsu_q;
        grant_lsu_d = grant_lsu_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        case (state_q)
            IDLE: begin
                if (ifu_acc) begin
                    grant_lsu_d = 1'b0;
                    addr_d      = ifu.addr;
                    wen_d       = 1'b0;
                    wdata_d     = 32'd0;
                    wmask_d     = 4'd0;
                    state_d     = REQ;
                end else if (lsu_acc) begin
                    grant_lsu_d = 1'b1;
                    addr_d      = lsu.addr;
                    wen_d       = lsu.wen;
                    wdata_d     = lsu.wdata;
                    wmask_d     = lsu.wmask;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (mem.req_ready) state_d = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    last_lsu_d = grant_lsu_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_lsu_q  <= 1'b1;
            grant_lsu_q <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= 32'd0;
            wmask_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            last_lsu_q  <= last_lsu_d;
            grant_lsu_q <= grant_lsu_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
        end
    end

    assign ifu.req_ready = ifu_acc;
    assign lsu.req_ready = lsu_acc;

    assign mem.req_valid = (state_q == REQ);
    assign mem.addr      = addr_q;
    assign mem.wen       = wen_q;
    assign mem.wdata     = wdata_q;
    assign mem.wmask     = wmask_q;
    assign mem.rsp_ready = in_resp && rsp_ready_sel;

    // Response path is combinational from memory; stores return zero data.
    assign ifu.rsp_valid = in_resp && !grant_lsu_q && mem.rsp_valid;
    assign ifu.rdata     = (in_resp && !grant_lsu_q) ? mem.rdata : 32'd0;
    assign lsu.rsp_valid = in_resp && grant_lsu_q && mem.rsp_valid;
    assign lsu.rdata     = (in_resp && grant_lsu_q && !wen_q) ? mem.rdata : 32'd0;

    assign busy      = (state_q != IDLE);
    assign grant_lsu = grant_lsu_q;

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Bench for ysyx_mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_ysyx_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, grant_lsu;

    always #5 clk = ~clk;

    ysyx_mem_arbiter_if #(.ADDR_W(32)) ifu_b ();
    ysyx_mem_arbiter_if #(.ADDR_W(32)) lsu_b ();
    ysyx_mem_arbiter_if #(.ADDR_W(32)) mem_b ();

    ysyx_mem_arbiter #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .ifu       (ifu_b),
        .lsu       (lsu_b),
        .mem       (mem_b),
        .busy      (busy),
        .grant_lsu (grant_lsu)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 = free, 1 = transaction waiting for memory to accept,
    // 2 = waiting for the owner to take the response.
    bit          m_live = 1'b0;
    int          m_phase = 0;
    bit          m_own, m_last, m_grant, m_wen;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wmask;

    logic        e_ifu_rdy, e_lsu_rdy, e_ifu_rv, e_lsu_rv, e_mreq, e_mrr, e_busy;
    logic [31:0] e_ifu_rd, e_lsu_rd;

    always_comb begin
        e_ifu_rdy = 1'b0; e_lsu_rdy = 1'b0;
        e_ifu_rv  = 1'b0; e_lsu_rv  = 1'b0;
        e_ifu_rd  = 32'd0; e_lsu_rd = 32'd0;
        e_mreq    = 1'b0; e_mrr     = 1'b0;
        e_busy    = (m_phase != 0);
        if (m_phase == 0) begin
            if (ifu_b.req_valid && lsu_b.req_valid) begin
                e_ifu_rdy = m_last;
                e_lsu_rdy = !m_last;
            end else begin
                e_ifu_rdy = ifu_b.req_valid;
                e_lsu_rdy = lsu_b.req_valid;
            end
        end else if (m_phase == 1) begin
            e_mreq = 1'b1;
        end else begin
            e_mrr = m_own ? lsu_b.rsp_ready : ifu_b.rsp_ready;
            if (m_own) begin
                e_lsu_rv = mem_b.rsp_valid;
                e_lsu_rd = m_wen ? 32'd0 : mem_b.rdata;
            end else begin
                e_ifu_rv = mem_b.rsp_valid;
                e_ifu_rd = mem_b.rdata;
            end
        end
    end

    bit ih, lh;
    always @(posedge clk) begin
        ih = ifu_b.req_valid && e_ifu_rdy;
        lh = lsu_b.req_valid && e_lsu_rdy;
        if (rst) begin
            m_live = 1'b1; m_phase = 0; m_last = 1'b1; m_grant = 1'b0; m_own = 1'b0;
            m_addr = 32'd0; m_wen = 1'b0; m_wdata = 32'd0; m_wmask = 4'd0;
        end else if (m_live) begin
            if (m_phase == 0) begin
                if (ih) begin
                    m_own = 1'b0; m_grant = 1'b0; m_addr = ifu_b.addr;
                    m_wen = 1'b0; m_wdata = 32'd0; m_wmask = 4'd0; m_phase = 1;
                end else if (lh) begin
                    m_own = 1'b1; m_grant = 1'b1; m_addr = lsu_b.addr;
                    m_wen = lsu_b.wen; m_wdata = lsu_b.wdata; m_wmask = lsu_b.wmask; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (mem_b.req_ready) m_phase = 2;
            end else if (mem_b.rsp_valid && e_mrr) begin
                m_last  = m_own;
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk1 ("ifu_req_ready", ifu_b.req_ready, e_ifu_rdy);
            chk1 ("lsu_req_ready", lsu_b.req_ready, e_lsu_rdy);
            chk1 ("ifu_rsp_valid", ifu_b.rsp_valid, e_ifu_rv);
            chk32("ifu_rdata",     ifu_b.rdata,     e_ifu_rd);
            chk1 ("lsu_rsp_valid", lsu_b.rsp_valid, e_lsu_rv);
            chk32("lsu_rdata",     lsu_b.rdata,     e_lsu_rd);
            chk1 ("mem_req_valid", mem_b.req_valid, e_mreq);
            chk32("mem_addr",      mem_b.addr,      m_addr);
            chk1 ("mem_wen",       mem_b.wen,       m_wen);
            chk32("mem_wdata",     mem_b.wdata,     m_wdata);
            chk32("mem_wmask",     {28'd0, mem_b.wmask}, {28'd0, m_wmask});
            chk1 ("mem_rsp_ready", mem_b.rsp_ready, e_mrr);
            chk1 ("busy",          busy,            e_busy);
            chk1 ("grant_lsu",     grant_lsu,       m_grant);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit ip, lp, ia, la;
    logic [3:0] masks [3];

    initial begin
        masks[0] = 4'b1111; masks[1] = 4'b0011; masks[2] = 4'b0001;
        ifu_b.req_valid = 0; ifu_b.addr = 0; ifu_b.wen = 1; ifu_b.wdata = 32'hFFFF_FFFF;
        ifu_b.wmask = 4'hF; ifu_b.rsp_ready = 0;
        lsu_b.req_valid = 0; lsu_b.addr = 0; lsu_b.wen = 0; lsu_b.wdata = 0;
        lsu_b.wmask = 0; lsu_b.rsp_ready = 0;
        mem_b.req_ready = 0; mem_b.rsp_valid = 0; mem_b.rdata = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        @(negedge clk);
        chk1 ("reset busy", busy, 1'b0);
        chk1 ("reset grant_lsu", grant_lsu, 1'b0);
        chk1 ("reset mem_req_valid", mem_b.req_valid, 1'b0);
        chk32("reset mem_addr", mem_b.addr, 32'd0);

        // single IFU read; IFU write-side fields carry junk that must be dropped
        tick();
        ifu_b.req_valid = 1; ifu_b.addr = 32'h8000_0000; ifu_b.rsp_ready = 1;
        mem_b.req_ready = 1;
        @(negedge clk); chk1("t1 ifu_req_ready c0", ifu_b.req_ready, 1'b1);
        tick(); ifu_b.req_valid = 0;
        @(negedge clk);
        chk1 ("t1 mem_req_valid c1", mem_b.req_valid, 1'b1);
        chk32("t1 mem_addr c1", mem_b.addr, 32'h8000_0000);
        chk1 ("t1 mem_wen c1", mem_b.wen, 1'b0);
        chk32("t1 mem_wmask c1", {28'd0, mem_b.wmask}, 32'd0);
        tick(); mem_b.rsp_valid = 1; mem_b.rdata = 32'h0000_0413;
        @(negedge clk);
        chk1 ("t1 ifu_rsp_valid c2", ifu_b.rsp_valid, 1'b1);
        chk32("t1 ifu_rdata c2", ifu_b.rdata, 32'h0000_0413);
        chk1 ("t1 lsu_rsp_valid c2", lsu_b.rsp_valid, 1'b0);
        tick(); mem_b.rsp_valid = 0;
        @(negedge clk); chk1("t1 busy c3", busy, 1'b0);

        // LSU word store
        tick();
        lsu_b.req_valid = 1; lsu_b.addr = 32'h8000_1000; lsu_b.wen = 1;
        lsu_b.wdata = 32'hDEAD_BEEF; lsu_b.wmask = 4'b1111; lsu_b.rsp_ready = 1;
        @(negedge clk); chk1("t2 lsu_req_ready", lsu_b.req_ready, 1'b1);
        tick(); lsu_b.req_valid = 0;
        @(negedge clk);
        chk1 ("t2 mem_wen", mem_b.wen, 1'b1);
        chk32("t2 mem_wdata", mem_b.wdata, 32'hDEAD_BEEF);
        chk32("t2 mem_wmask", {28'd0, mem_b.wmask}, 32'h0000_000F);
        tick(); mem_b.rsp_valid = 1; mem_b.rdata = 32'h1234_5678;
        @(negedge clk);
        chk1 ("t2 lsu_rsp_valid", lsu_b.rsp_valid, 1'b1);
        chk32("t2 lsu_rdata", lsu_b.rdata, 32'd0);
        tick(); mem_b.rsp_valid = 0;

        // contention from reset: both held, memory always ready
        rst = 1; tick(); rst = 0;
        ifu_b.req_valid = 1; lsu_b.req_valid = 1; lsu_b.wen = 0;
        mem_b.req_ready = 1; mem_b.rsp_valid = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk1("t3 ifu_req_ready", ifu_b.req_ready, 1'((k % 2) == 0));
            chk1("t3 lsu_req_ready", lsu_b.req_ready, 1'(k % 2));
            tick();
            @(negedge clk);
            chk1("t3 grant_lsu", grant_lsu, 1'(k % 2));
            tick(); tick();
        end
        ifu_b.req_valid = 0; lsu_b.req_valid = 0; mem_b.rsp_valid = 0; mem_b.req_ready = 0;

        // backpressure on both memory request and LSU response
        tick();
        lsu_b.req_valid = 1; lsu_b.addr = 32'h8000_2000; lsu_b.wen = 0;
        lsu_b.wmask = 4'b0011; lsu_b.wdata = 32'h55; lsu_b.rsp_ready = 0;
        @(negedge clk); chk1("t4 lsu_req_ready", lsu_b.req_ready, 1'b1);
        tick(); lsu_b.req_valid = 0;
        repeat (5) begin
            @(negedge clk);
            chk1 ("t4 mem_req_valid held", mem_b.req_valid, 1'b1);
            chk32("t4 mem_addr held", mem_b.addr, 32'h8000_2000);
            chk32("t4 mem_wmask held", {28'd0, mem_b.wmask}, 32'h3);
            tick();
        end
        mem_b.req_ready = 1;
        tick(); mem_b.req_ready = 0; mem_b.rsp_valid = 1; mem_b.rdata = 32'hCAFE_F00D;
        repeat (3) begin
            @(negedge clk);
            chk1 ("t4 lsu_rsp_valid stalled", lsu_b.rsp_valid, 1'b1);
            chk1 ("t4 mem_rsp_ready stalled", mem_b.rsp_ready, 1'b0);
            chk32("t4 lsu_rdata", lsu_b.rdata, 32'hCAFE_F00D);
            tick();
        end
        lsu_b.rsp_ready = 1;
        @(negedge clk); chk1("t4 mem_rsp_ready", mem_b.rsp_ready, 1'b1);
        tick();
        // memory keeps rsp_valid high in IDLE: must be ignored
        repeat (2) begin
            @(negedge clk);
            chk1("t6 lsu_rsp_valid stray", lsu_b.rsp_valid, 1'b0);
            chk1("t6 ifu_rsp_valid stray", ifu_b.rsp_valid, 1'b0);
            chk1("t6 busy stray", busy, 1'b0);
            tick();
        end
        mem_b.rsp_valid = 0;

        // reset while waiting for a response
        ifu_b.req_valid = 1; ifu_b.addr = 32'h8000_0010; ifu_b.rsp_ready = 1; mem_b.req_ready = 1;
        tick(); ifu_b.req_valid = 0;
        tick(); rst = 1;
        @(negedge clk); chk1("t5 busy in resp", busy, 1'b1);
        tick(); rst = 0; mem_b.rsp_valid = 1;
        @(negedge clk);
        chk1 ("t5 busy after rst", busy, 1'b0);
        chk1 ("t5 ifu_rsp_valid after rst", ifu_b.rsp_valid, 1'b0);
        chk1 ("t5 grant_lsu after rst", grant_lsu, 1'b0);
        chk32("t5 mem_addr after rst", mem_b.addr, 32'd0);
        tick(); mem_b.rsp_valid = 0;
        ifu_b.req_valid = 1; ifu_b.addr = 32'h8000_0020;
        @(negedge clk); chk1("t5 ifu_req_ready", ifu_b.req_ready, 1'b1);
        tick(); ifu_b.req_valid = 0;
        @(negedge clk); chk32("t5 mem_addr", mem_b.addr, 32'h8000_0020);
        tick(); mem_b.rsp_valid = 1; mem_b.rdata = 32'h0010_0073;
        @(negedge clk);
        chk1 ("t5 ifu_rsp_valid", ifu_b.rsp_valid, 1'b1);
        chk32("t5 ifu_rdata", ifu_b.rdata, 32'h0010_0073);
        tick(); mem_b.rsp_valid = 0;
        @(negedge clk); chk1("t5 busy end", busy, 1'b0);

        // randomized traffic; masters hold requests until accepted
        ip = 0; lp = 0;
        repeat (4000) begin
            @(negedge clk);
            ia = ifu_b.req_valid && ifu_b.req_ready;
            la = lsu_b.req_valid && lsu_b.req_ready;
            tick();
            if (ia) ip = 0;
            if (la) lp = 0;
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1;
                ifu_b.addr  = $urandom;
                ifu_b.wen   = 1'($urandom);
                ifu_b.wdata = $urandom;
                ifu_b.wmask = 4'($urandom);
            end
            if (!lp && $urandom_range(0, 2) == 0) begin
                lp = 1;
                lsu_b.addr  = $urandom;
                lsu_b.wen   = 1'($urandom);
                lsu_b.wdata = $urandom;
                lsu_b.wmask = masks[$urandom_range(0, 2)];
            end
            ifu_b.req_valid = ip;
            lsu_b.req_valid = lp;
            ifu_b.rsp_ready = ($urandom_range(0, 3) != 0);
            lsu_b.rsp_ready = ($urandom_range(0, 3) != 0);
            mem_b.req_ready = ($urandom_range(0, 2) != 0);
            mem_b.rsp_valid = ($urandom_range(0, 1) != 0);
            mem_b.rdata     = $urandom;
            rst             = ($urandom_range(0, 199) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
